// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: Pong game sequencer (menu, settings, serve countdown, play, game-over hold); define PAUSE_EN to add a pause state
module game_flow_ctrl #(
  parameter int COUNT_FRAMES     = 60,
  parameter int COUNT_SECS       = 3,
  parameter int OVER_HOLD_FRAMES = 300,
  parameter int SPEED_MIN        = 1,
  parameter int SPEED_MAX        = 8,
  parameter int SPEED_DEFAULT    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       start_p,
  input  logic       setting_p,
  input  logic       up_p,
  input  logic       down_p,
  input  logic       game_over_in,
  output logic [2:0] game_state,
  output logic       game_active,
  output logic       round_reset,
  output logic [3:0] countdown,
  output logic [3:0] ball_speed,
  output logic       multi_ball
);
  typedef enum logic [2:0] {
    S_MENU      = 3'd0,
    S_SETTINGS  = 3'd1,
    S_COUNTDOWN = 3'd2,
    S_PLAY      = 3'd3,
`ifdef PAUSE_EN
    S_PAUSE     = 3'd4,
`endif
    S_OVER      = 3'd5
  } state_t;
  localparam int FW = COUNT_FRAMES > 1 ? $clog2(COUNT_FRAMES) : 1;
  localparam int HW = OVER_HOLD_FRAMES > 1 ? $clog2(OVER_HOLD_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(COUNT_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(OVER_HOLD_FRAMES - 1);
  localparam logic [3:0] SMAX = 4'(SPEED_MAX);
  localparam logic [3:0] SMIN = 4'(SPEED_MIN);
  localparam logic [3:0] SDEF = 4'(SPEED_DEFAULT);
  localparam logic [3:0] CSECS = 4'(COUNT_SECS);
  state_t state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0] countdown_q, countdown_d, speed_q, speed_d;
  logic multi_q, multi_d, round_reset_q, round_reset_d;
  // next state, counters and settings; entry actions are applied after the per-state decisions
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    hold_d = hold_q;
    countdown_d = countdown_q;
    speed_d = speed_q;
    multi_d = multi_q;
    case (state_q)
      S_MENU: state_d = start_p ? S_COUNTDOWN : setting_p ? S_SETTINGS : S_MENU;
      S_SETTINGS: begin
        if (start_p) state_d = S_MENU;
        else begin
          if (up_p && !down_p && speed_q < SMAX) speed_d = speed_q + 4'd1;
          if (down_p && !up_p && speed_q > SMIN) speed_d = speed_q - 4'd1;
          if (setting_p) multi_d = !multi_q;
        end
      end
      S_COUNTDOWN: begin
        if (setting_p) state_d = S_MENU;
        else if (refresh_tick) begin
          if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            countdown_d = countdown_q - 4'd1;
            if (countdown_q == 4'd1) state_d = S_PLAY;
          end else frame_d = frame_q + FW'(1);
        end
      end
      S_PLAY: begin
        if (game_over_in) state_d = S_OVER;
        else if (setting_p) state_d = S_MENU;
`ifdef PAUSE_EN
        else if (start_p) state_d = S_PAUSE;
`endif
      end
`ifdef PAUSE_EN
      S_PAUSE: state_d = start_p ? S_PLAY : setting_p ? S_MENU : S_PAUSE;
`endif
      S_OVER: begin
        if (start_p) state_d = S_MENU;
        else if (refresh_tick) begin
          if (hold_q == HOLD_LAST) state_d = S_MENU;
          else hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = S_MENU;
    endcase
    round_reset_d = state_d == S_COUNTDOWN && state_q != S_COUNTDOWN;
    if (round_reset_d) frame_d = '0;
    countdown_d = state_d != S_COUNTDOWN ? 4'd0 : round_reset_d ? CSECS : countdown_d;
    if (state_d == S_OVER && state_q != S_OVER) hold_d = '0;
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_MENU;
      frame_q <= '0;
      hold_q <= '0;
      countdown_q <= 4'd0;
      speed_q <= SDEF;
      multi_q <= 1'b0;
      round_reset_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      hold_q <= hold_d;
      countdown_q <= countdown_d;
      speed_q <= speed_d;
      multi_q <= multi_d;
      round_reset_q <= round_reset_d;
    end
  end
  assign game_state = state_q;
  assign game_active = state_q == S_PLAY;
  assign round_reset = round_reset_q;
  assign countdown = countdown_q;
  assign ball_speed = speed_q;
  assign multi_ball = multi_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: vector table, hand sequences and random stimulus against a behavioural model of game_flow_ctrl
module tb_game_flow_ctrl;
  localparam logic [6:0] R = 7'b1000000, ST = 7'b0100000, SE = 7'b0010000, UP = 7'b0001000;
  localparam logic [6:0] DN = 7'b0000100, TK = 7'b0000010, GO = 7'b0000001, IDLE = 7'b0;
  localparam int CF = 60, CS = 3, OH = 300, SMIN = 1, SMAX = 8, SDEF = 4;
`ifdef PAUSE_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, refresh_tick = 1'b0, start_p = 1'b0, setting_p = 1'b0;
  logic up_p = 1'b0, down_p = 1'b0, game_over_in = 1'b0;
  logic [2:0] game_state;
  logic game_active, round_reset, multi_ball;
  logic [3:0] countdown, ball_speed;
  int checks = 0, errors = 0;
  int m_st = 0, m_sp = SDEF, m_mu = 0, m_rr = 0, m_cdt = 0, m_ovt = 0;
  typedef struct {
    logic [6:0] in;
    int es, esp, em, err, ecd;
  } vec_t;
  vec_t tv[18];
  game_flow_ctrl dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .start_p(start_p),
    .setting_p(setting_p), .up_p(up_p), .down_p(down_p), .game_over_in(game_over_in),
    .game_state(game_state), .game_active(game_active), .round_reset(round_reset),
    .countdown(countdown), .ball_speed(ball_speed), .multi_ball(multi_ball)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input int e);
    checks++;
    if (a !== 32'(e)) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic mstep(input logic [6:0] v);
    logic r, st, se, up, dn, tk, go;
    {r, st, se, up, dn, tk, go} = v;
    m_rr = 0;
    if (r) begin
      m_st = 0; m_sp = SDEF; m_mu = 0;
    end else case (m_st)
      0: if (st) begin m_st = 2; m_cdt = 0; m_rr = 1; end else if (se) m_st = 1;
      1: if (st) m_st = 0;
         else begin
           if (up && !dn) m_sp = m_sp + 1 > SMAX ? SMAX : m_sp + 1;
           if (dn && !up) m_sp = m_sp - 1 < SMIN ? SMIN : m_sp - 1;
           if (se) m_mu = 1 - m_mu;
         end
      2: if (se) m_st = 0;
         else if (tk) begin m_cdt++; if (m_cdt == CS * CF) m_st = 3; end
      3: if (go) begin m_st = 5; m_ovt = 0; end
         else if (se) m_st = 0;
         else if (st && PE) m_st = 4;
      4: if (st) m_st = 3; else if (se) m_st = 0;
      5: if (st) m_st = 0;
         else if (tk) begin m_ovt++; if (m_ovt == OH) m_st = 0; end
      default: m_st = 0;
    endcase
  endtask
  task automatic cyc(input logic [6:0] v);
    {reset, start_p, setting_p, up_p, down_p, refresh_tick, game_over_in} = v;
    mstep(v);
    @(posedge clk);
    #1;
    chk("m_state", 32'(game_state), m_st);
    chk("m_active", 32'(game_active), m_st == 3 ? 1 : 0);
    chk("m_round_reset", 32'(round_reset), m_rr);
    chk("m_countdown", 32'(countdown), m_st == 2 ? CS - m_cdt / CF : 0);
    chk("m_speed", 32'(ball_speed), m_sp);
    chk("m_multi", 32'(multi_ball), m_mu);
  endtask
  task automatic to_play();
    cyc(ST);
    for (int i = 0; i < CS * CF; i++) cyc(TK);
    chk("to_play_state", 32'(game_state), 3);
  endtask
  function automatic logic rnd(input int n);
    return $urandom_range(0, n - 1) == 0;
  endfunction
  initial begin
    logic [6:0] v;
    logic go_l;
    tv[0] = '{R, 0, 4, 0, 0, 0};          tv[1] = '{SE, 1, 4, 0, 0, 0};
    tv[2] = '{UP, 1, 5, 0, 0, 0};         tv[3] = '{UP, 1, 6, 0, 0, 0};
    tv[4] = '{UP, 1, 7, 0, 0, 0};         tv[5] = '{UP, 1, 8, 0, 0, 0};
    tv[6] = '{UP, 1, 8, 0, 0, 0};         tv[7] = '{UP, 1, 8, 0, 0, 0};
    tv[8] = '{UP | DN, 1, 8, 0, 0, 0};    tv[9] = '{SE, 1, 8, 1, 0, 0};
    tv[10] = '{ST, 0, 8, 1, 0, 0};        tv[11] = '{UP, 0, 8, 1, 0, 0};
    tv[12] = '{ST | SE, 2, 8, 1, 1, 3};   tv[13] = '{TK, 2, 8, 1, 0, 3};
    tv[14] = '{SE, 0, 8, 1, 0, 0};        tv[15] = '{SE, 1, 8, 1, 0, 0};
    tv[16] = '{DN | SE, 1, 7, 0, 0, 0};   tv[17] = '{ST | UP, 0, 7, 0, 0, 0};
    for (int i = 0; i < 18; i++) begin
      cyc(tv[i].in);
      chk($sformatf("tv%0d_state", i), 32'(game_state), tv[i].es);
      chk($sformatf("tv%0d_speed", i), 32'(ball_speed), tv[i].esp);
      chk($sformatf("tv%0d_multi", i), 32'(multi_ball), tv[i].em);
      chk($sformatf("tv%0d_rr", i), 32'(round_reset), tv[i].err);
      chk($sformatf("tv%0d_cd", i), 32'(countdown), tv[i].ecd);
    end
    cyc(R);
    chk("rst_active", 32'(game_active), 0);
    cyc(ST);
    chk("cd_entry_rr", 32'(round_reset), 1);
    chk("cd_entry_val", 32'(countdown), 3);
    cyc(IDLE);
    chk("cd_rr_once", 32'(round_reset), 0);
    for (int i = 1; i < CS * CF; i++) begin
      cyc(TK);
      if (i == CF) chk("cd_after_60", 32'(countdown), 2);
    end
    chk("cd_179_state", 32'(game_state), 2);
    chk("cd_179_val", 32'(countdown), 1);
    cyc(TK);
    chk("cd_180_state", 32'(game_state), 3);
    chk("cd_180_val", 32'(countdown), 0);
    chk("cd_180_active", 32'(game_active), 1);
    cyc(GO | SE);
    chk("over_prio", 32'(game_state), 5);
    for (int i = 1; i < OH; i++) cyc(TK | GO);
    chk("over_299", 32'(game_state), 5);
    cyc(TK | GO);
    chk("over_300", 32'(game_state), 0);
    to_play();
    cyc(GO);
    chk("over2_state", 32'(game_state), 5);
    cyc(TK);
    cyc(ST);
    chk("over_start", 32'(game_state), 0);
    to_play();
    cyc(ST);
    chk("pause_state", 32'(game_state), PE ? 4 : 3);
    chk("pause_active", 32'(game_active), PE ? 0 : 1);
    cyc(GO);
    chk("pause_go", 32'(game_state), PE ? 4 : 5);
    cyc(ST);
    chk("resume_state", 32'(game_state), PE ? 3 : 0);
    chk("resume_rr", 32'(round_reset), 0);
    cyc(R);
    cyc(SE);
    cyc(DN);
    chk("t6_speed3", 32'(ball_speed), 3);
    cyc(ST);
    cyc(ST);
    for (int i = 0; i < CF; i++) cyc(TK);
    chk("t6_cd2", 32'(countdown), 2);
    cyc(R);
    chk("t6_state", 32'(game_state), 0);
    chk("t6_cd", 32'(countdown), 0);
    chk("t6_speed", 32'(ball_speed), 4);
    go_l = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      v = IDLE;
      case (m_st)
        0: begin v[5] = rnd(6); v[4] = rnd(4); end
        1: begin v[3] = rnd(3); v[2] = rnd(3); v[4] = rnd(4); v[5] = rnd(12); end
        2: begin v[4] = rnd(1500); v[5] = rnd(20); v[1] = !rnd(4); end
        3: begin v[5] = rnd(30); v[4] = rnd(150); go_l = go_l | rnd(80); end
        4: begin v[5] = rnd(8); v[4] = rnd(40); v[1] = rnd(2); end
        default: begin v[5] = rnd(400); v[1] = !rnd(4); end
      endcase
      if (m_st < 3) go_l = 1'b0;
      v[0] = go_l;
      v[3] = v[3] | rnd(6);
      v[2] = v[2] | rnd(6);
      v[1] = v[1] | rnd(3);
      v[6] = rnd(4000);
      cyc(v);
    end
    cyc(IDLE);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
